// File: rtl/glitch_free_pkg.sv
// Shared types and helpers for the glitch-free divided-clock switch.
package glitch_free_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } gf_state_e;

  localparam int GAP_MIN = 1;

  // Divisors below 2 cannot form a high and a low phase, so they become 2.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    if (d < 32'd2) begin
      return 32'd2;
    end else begin
      return d;
    end
  endfunction

endpackage

// File: rtl/gf_div_counter.sv
// Period counter with a divisor latched at cnt == 0; produces the registered
// divided clock and the end-of-period pulse.
module gf_div_counter
  import glitch_free_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic [CW-1:0] divisor,
  output logic          last,
  output logic          clkout,
  output logic          period_end
);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] d_r;
  logic [CW-1:0] d_eff_s;
  logic [CW-1:0] half_s;
  logic          clkout_r;
  logic          period_end_r;

  // The divisor in force this cycle: a fresh sample at the period start.
  always_comb begin
    d_eff_s = d_r;
    if (cnt_r == '0) begin
      d_eff_s = CW'(clamp_div(32'(divisor)));
    end else begin
      d_eff_s = d_r;
    end
    half_s = d_eff_s >> 1;
    last   = (cnt_r == (d_eff_s - CW'(1)));
  end

  // Counter, divisor latch and registered outputs; hold parks everything low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= '0;
      d_r          <= CW'(2);
      clkout_r     <= 1'b0;
      period_end_r <= 1'b0;
    end else if (hold) begin
      cnt_r        <= '0;
      clkout_r     <= 1'b0;
      period_end_r <= 1'b0;
    end else begin
      d_r          <= d_eff_s;
      clkout_r     <= (cnt_r < half_s);
      period_end_r <= last;
      cnt_r        <= last ? '0 : (cnt_r + CW'(1));
    end
  end

  assign clkout     = clkout_r;
  assign period_end = period_end_r;

endmodule

// File: rtl/glitch_free_div_switch.sv
// Break-before-make divided-clock selector: channel changes wait for the end
// of the current period, then force clkout low for GAP cycles.
module glitch_free_div_switch
  import glitch_free_pkg::*;
#(
  parameter  int NCH = 4,
  parameter  int CW  = 8,
  parameter  int GAP = 2,
  localparam int SW  = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH*CW-1:0] div_cfg,
  input  logic [SW-1:0]   sel,
  input  logic            sel_valid,
  output logic            sel_ready,
  output logic            sel_err,
  output logic [SW-1:0]   cur_sel,
  output logic            busy,
  output logic            period_end,
  output logic            clkout
);

  localparam int GW = (GAP > GAP_MIN) ? $clog2(GAP) : 1;

  gf_state_e     state_r;
  logic [SW-1:0] cur_sel_r;
  logic [SW-1:0] pend_sel_r;
  logic [GW-1:0] gap_cnt_r;
  logic          sel_ready_r;
  logic          busy_r;
  logic          sel_err_r;
  logic          last_s;
  logic          hold_s;
  logic [CW-1:0] divisor_s;
  logic          accept_s;

  assign hold_s    = (state_r == ST_GAP);
  assign divisor_s = div_cfg[int'(cur_sel_r)*CW +: CW];
  assign accept_s  = sel_valid && sel_ready_r;

  gf_div_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold_s),
    .divisor    (divisor_s),
    .last       (last_s),
    .clkout     (clkout),
    .period_end (period_end)
  );

  // Switch FSM with handshake; ready/busy are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      cur_sel_r   <= '0;
      pend_sel_r  <= '0;
      gap_cnt_r   <= '0;
      sel_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      sel_err_r   <= 1'b0;
    end else begin
      sel_err_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (accept_s) begin
            if (32'(sel) >= 32'(NCH)) begin
              sel_err_r <= 1'b1;
            end else if (sel != cur_sel_r) begin
              pend_sel_r  <= sel;
              gap_cnt_r   <= '0;
              sel_ready_r <= 1'b0;
              busy_r      <= 1'b1;
              state_r     <= last_s ? ST_GAP : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (last_s) begin
            state_r <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GW'(GAP - 1)) begin
            state_r     <= ST_RUN;
            cur_sel_r   <= pend_sel_r;
            sel_ready_r <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: begin
          state_r     <= ST_RUN;
          sel_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign sel_ready = sel_ready_r;
  assign sel_err   = sel_err_r;
  assign busy      = busy_r;
  assign cur_sel   = cur_sel_r;

endmodule

// File: tb/tb_glitch_free_div_switch.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a negedge
// monitor pops and compares them.
module tb_glitch_free_div_switch;

  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int GAP = 2;
  localparam int SW  = 2;

  typedef struct packed {
    logic          ck;
    logic          pe;
    logic          busy;
    logic          rdy;
    logic          err;
    logic [SW-1:0] cur;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*CW-1:0] div_cfg;
  logic [SW-1:0]     sel;
  logic              sel_valid;
  logic              sel_ready;
  logic              sel_err;
  logic [SW-1:0]     cur_sel;
  logic              busy;
  logic              period_end;
  logic              clkout;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  glitch_free_div_switch #(.NCH(NCH), .CW(CW), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_cfg    (div_cfg),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .sel_err    (sel_err),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .period_end (period_end),
    .clkout     (clkout)
  );

  always #5 clk = ~clk;

  // Monitor: compare every expected record at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = '{clkout, period_end, busy, sel_ready, sel_err, cur_sel};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got ck/pe/busy/rdy/err/cur=%b/%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%b/%0d",
                 n, a.ck, a.pe, a.busy, a.rdy, a.err, a.cur,
                 e.ck, e.pe, e.busy, e.rdy, e.err, e.cur);
      end
    end
  end

  task automatic tick(input logic ck, input logic pe, input logic bsy,
                      input logic rdy, input logic err, input logic [SW-1:0] cur,
                      input string n);
    @(posedge clk);
    #1;
    exp_q.push_back('{ck, pe, bsy, rdy, err, cur});
    name_q.push_back(n);
  endtask

  // One idle RUN period of divisor d on channel cur: floor(d/2) high, rest low.
  task automatic period(input int d, input logic [SW-1:0] cur, input string n);
    for (int i = 0; i < d; i++) begin
      tick(i < d / 2, i == d - 1, 1'b0, 1'b1, 1'b0, cur, n);
    end
  endtask

  task automatic set_div(input int ch, input int d);
    div_cfg[ch*CW +: CW] = CW'(d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sel = '0; sel_valid = 1'b0; div_cfg = '0;
    set_div(0, 4); set_div(1, 5); set_div(2, 3);

    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "reset_state");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "reset_state");
    rst = 1'b0;
    period(4, 2'd0, "d4_period");
    period(4, 2'd0, "d4_period");

    // Mid-period divisor change: old D=4 finishes, then D=5.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "d4_cnt0");
    set_div(0, 5);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "midchg_old_d");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "midchg_old_d");
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "midchg_old_d_end");
    period(5, 2'd0, "d5_odd");
    period(5, 2'd0, "d5_odd");
    set_div(0, 0);
    period(2, 2'd0, "d0_clamped");
    period(2, 2'd0, "d0_clamped");
    set_div(0, 1);
    period(2, 2'd0, "d1_clamped");
    set_div(0, 6);
    period(6, 2'd0, "d6_period");

    // Switch 0->2 accepted at cnt=1; request held while not ready.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "sw_cnt0");
    sel = 2'd2; sel_valid = 1'b1;
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "sw_accept");
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "sw_wait_hi");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "sw_wait_lo");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "sw_wait_lo");
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "sw_wait_end");
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "sw_gap1");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "sw_gap2");
    period(3, 2'd2, "ch2_held_noop");
    sel_valid = 1'b0;
    period(3, 2'd2, "ch2_period");

    // Boundary accept 2->0 at cnt == D-1: straight into GAP.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "bnd_cnt0");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, "bnd_cnt1");
    sel = 2'd0; sel_valid = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, "bnd_accept");
    sel_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, "bnd_gap1");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "bnd_gap2");
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "bnd_first_high");
    for (int i = 1; i < 6; i++) begin
      tick(i < 3, i == 5, 1'b0, 1'b1, 1'b0, 2'd0, "bnd_new_period");
    end

    // No-op (same channel) and out-of-range request.
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "noop_cnt0");
    sel = 2'd0; sel_valid = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "noop_same");
    sel = 2'd3;
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, "err_pulse");
    sel_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "err_cleared");
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "err_after");
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, "err_after_end");

    // Reset during GAP abandons the switch to channel 1.
    for (int i = 0; i < 5; i++) begin
      tick(i < 3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "rg_period");
    end
    sel = 2'd1; sel_valid = 1'b1;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, "rg_accept");
    sel_valid = 1'b0;
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, "rg_gap1");
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, "rg_reset");
    rst = 1'b0;
    period(6, 2'd0, "rg_restart");

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
